// File: rtl/nibble_serial_addsub_if.sv
// Handshake and operand/result bundle for the nibble-serial add/sub sequencer.
// master drives start/mode/a/b; slave returns busy/done/result and flags.
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    modport master (
        output start, mode, a, b,
        input  busy, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract using one 4-bit ripple slice, one nibble per clock.
// Ports: clk, rst (sync, active high), bus (slave: start/mode/a/b in, busy/done/result/flags out).
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input logic                   clk,
    input logic                   rst,
    nibble_serial_addsub_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_nx;
    logic          mode_l;
    logic          carry_reg;
    logic [IW-1:0] idx;
    logic          co_q;
    logic          ov_q;
    logic          z_q;

    logic          accept;
    logic          last;

    logic [3:0]    a_nib;
    logic [3:0]    bx_nib;
    logic [3:0]    lo;
    logic [3:0]    s_nib;
    logic          c3;
    logic          c4;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (idx == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The single 4-bit slice. Operands are shifted down each cycle, so the
    // active nibble is always the low one; subtract inverts b and seeds the
    // carry with 1. The low three bits are added separately so the carry into
    // bit 3 is available for the signed-overflow flag.
    assign a_nib  = a_sh[3:0];
    assign bx_nib = b_sh[3:0] ^ {4{mode_l}};
    assign lo     = {1'b0, a_nib[2:0]} + {1'b0, bx_nib[2:0]} + {3'b000, carry_reg};
    assign c3     = lo[3];
    assign s_nib  = {a_nib[3] ^ bx_nib[3] ^ c3, lo[2:0]};
    assign c4     = (a_nib[3] & bx_nib[3]) | (c3 & (a_nib[3] ^ bx_nib[3]));

    // Result with the current nibble merged in at position idx. Mask and
    // shift keep this free of out-of-range part selects when NIBBLES=1.
    always_comb begin
        res_nx = (res_q & ~(W'(4'hF) << (4 * idx)))
               | (W'(s_nib) << (4 * idx));
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            mode_l    <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            res_q     <= '0;
            co_q      <= 1'b0;
            ov_q      <= 1'b0;
            z_q       <= 1'b0;
        end else if (accept) begin
            a_sh      <= bus.a;
            b_sh      <= bus.b;
            mode_l    <= bus.mode;
            carry_reg <= bus.mode;
            idx       <= '0;
            res_q     <= '0;
            co_q      <= 1'b0;
            ov_q      <= 1'b0;
            z_q       <= 1'b0;
        end else if (state == RUN) begin
            a_sh      <= a_sh >> 4;
            b_sh      <= b_sh >> 4;
            carry_reg <= c4;
            idx       <= idx + IW'(1);
            res_q     <= res_nx;
            if (last) begin
                // Final nibble holds bit W-1, so its carries give the flags.
                co_q <= c4;
                ov_q <= c3 ^ c4;
                z_q  <= (res_nx == '0);
            end
        end
    end

    assign bus.result    = res_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
    assign bus.zero      = z_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: NIBBLES=4 and NIBBLES=1 instances on one clock/reset.
// Directed vectors, protocol scenarios and random operations against an arithmetic model.
module tb_nibble_serial_addsub;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nibble_serial_addsub_if #(.NIBBLES(4)) if4 ();
    nibble_serial_addsub_if #(.NIBBLES(1)) if1 ();

    nibble_serial_addsub #(.NIBBLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    nibble_serial_addsub #(.NIBBLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    typedef struct packed {
        logic [15:0] r;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    int checks = 0;
    int errors = 0;

    // Directed vectors for the 16-bit instance
    logic [15:0] ta [8] = '{16'h1234, 16'h1000, 16'h0000, 16'h7FFF,
                            16'h8000, 16'hFFFF, 16'h5A5A, 16'h0100};
    logic [15:0] tb [8] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0001,
                            16'h0001, 16'h0001, 16'h5A5A, 16'h0000};
    logic [15:0] tr [8] = '{16'h2233, 16'h0FFF, 16'hFFFF, 16'h8000,
                            16'h7FFF, 16'h0000, 16'h0000, 16'h0100};
    logic [7:0] tm  = 8'b1101_0110;
    logic [7:0] tco = 8'b1111_0010;
    logic [7:0] tov = 8'b0001_1000;
    logic [7:0] tz  = 8'b0110_0000;

    // Reference: plain integer arithmetic on w-bit values.
    function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic m);
        longint md;
        longint am;
        longint bm;
        longint s;
        longint sa;
        longint sb;
        longint ss;
        res_t   e;
        md = longint'(1) << w;
        am = longint'(a) % md;
        bm = longint'(b) % md;
        s  = m ? (am - bm) : (am + bm);
        e.co = m ? (am >= bm) : (s >= md);
        e.r  = 16'(((s % md) + md) % md);
        sa = (am >= md / 2) ? am - md : am;
        sb = (bm >= md / 2) ? bm - md : bm;
        ss = m ? (sa - sb) : (sa + sb);
        e.ov = (ss < -(md / 2)) || (ss >= md / 2);
        e.z  = (e.r == 16'h0);
        return e;
    endfunction

    task automatic drive(bit which, logic st, logic [15:0] a, logic [15:0] b, logic m);
        if (which) begin
            if1.start = st;
            if1.a     = a[3:0];
            if1.b     = b[3:0];
            if1.mode  = m;
        end else begin
            if4.start = st;
            if4.a     = a;
            if4.b     = b;
            if4.mode  = m;
        end
    endtask

    task automatic sample(bit which, output res_t o, output logic bsy, output logic dn);
        if (which) begin
            o   = {12'h000, if1.result, if1.carry_out, if1.overflow, if1.zero};
            bsy = if1.busy;
            dn  = if1.done;
        end else begin
            o   = {if4.result, if4.carry_out, if4.overflow, if4.zero};
            bsy = if4.busy;
            dn  = if4.done;
        end
    endtask

    // Issues one op; lat = edges after the accepting edge until done is seen
    // (-1 on timeout), bcnt = cycles with busy high. Inputs are scrambled
    // right after acceptance so only latched operands can matter.
    task automatic run_op(bit which, logic [15:0] a, logic [15:0] b, logic m,
                          output res_t o, output int lat, output int bcnt);
        logic bsy;
        logic dn;
        @(posedge clk);
        #1;
        drive(which, 1'b1, a, b, m);
        @(posedge clk);
        #1;
        drive(which, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        lat  = -1;
        bcnt = 0;
        o    = '0;
        for (int i = 0; i < 40; i++) begin
            sample(which, o, bsy, dn);
            if (dn) begin
                lat = i;
                break;
            end
            if (bsy) bcnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        res_t o;
        logic bsy;
        logic dn;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            sample(w[0], o, bsy, dn);
            checks++;
            if ({o, bsy, dn} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d got r=%h co=%b ov=%b z=%b busy=%b done=%b want all 0",
                         w, o.r, o.co, o.ov, o.z, bsy, dn);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        res_t o;
        int lat;
        int bcnt;
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, ta[i], tb[i], tm[i], o, lat, bcnt);
            checks++;
            if ({o.r, o.co, o.ov, o.z} !== {tr[i], tco[i], tov[i], tz[i]}) begin
                errors++;
                $display("FAIL directed_%0d got r=%h co=%b ov=%b z=%b want r=%h co=%b ov=%b z=%b",
                         i, o.r, o.co, o.ov, o.z, tr[i], tco[i], tov[i], tz[i]);
            end
            checks++;
            if (lat != 4 || bcnt != 4) begin
                errors++;
                $display("FAIL directed_latency_%0d got lat=%0d busy=%0d want lat=4 busy=4",
                         i, lat, bcnt);
            end
        end
    endtask

    task automatic test_ignored_start;
        res_t o;
        res_t got;
        logic bsy;
        logic dn;
        int dcnt;
        int bcnt;
        got = '0;
        dcnt = 0;
        bcnt = 0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        // Two RUN cycles remain here; a start raised during DONE must not
        // restart the sequencer.
        for (int i = 0; i < 12; i++) begin
            sample(1'b0, o, bsy, dn);
            if (bsy) bcnt++;
            if (dn) begin
                dcnt++;
                got = o;
                drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
            end else begin
                drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            end
            @(posedge clk);
            #1;
        end
        sample(1'b0, o, bsy, dn);
        checks++;
        if (got.r !== 16'h0002 || got.co !== 1'b0 || got.z !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result got r=%h co=%b z=%b want r=0002 co=0 z=0",
                     got.r, got.co, got.z);
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL ignore_start_done_count got %0d want 1", dcnt);
        end
        checks++;
        if (bcnt != 2) begin
            errors++;
            $display("FAIL ignore_start_busy_count got %0d want 2", bcnt);
        end
        checks++;
        if (o.r !== 16'h0002) begin
            errors++;
            $display("FAIL ignore_start_hold got r=%h want 0002", o.r);
        end
    endtask

    task automatic test_reset_mid_run;
        res_t o;
        logic bsy;
        logic dn;
        int dcnt;
        int bact;
        int lat;
        int bcnt;
        dcnt = 0;
        bact = 0;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample(1'b0, o, bsy, dn);
        checks++;
        if ({o, bsy, dn} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run got r=%h busy=%b done=%b flags=%b%b%b want all 0",
                     o.r, bsy, dn, o.co, o.ov, o.z);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            sample(1'b0, o, bsy, dn);
            if (dn) dcnt++;
            if (bsy) bact++;
        end
        checks++;
        if (dcnt != 0 || bact != 0) begin
            errors++;
            $display("FAIL reset_abort got done=%0d busy=%0d want 0 0", dcnt, bact);
        end
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, o, lat, bcnt);
        checks++;
        if (o.r !== 16'h0100 || o.co !== 1'b0 || o.ov !== 1'b0 || o.z !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL after_reset_op got r=%h co=%b ov=%b z=%b lat=%0d want r=0100 co=0 ov=0 z=0 lat=4",
                     o.r, o.co, o.ov, o.z, lat);
        end
    endtask

    task automatic test_nibbles1;
        res_t o;
        res_t e;
        int lat;
        int bcnt;
        logic [15:0] a;
        logic [15:0] b;
        logic m;
        run_op(1'b1, 16'h0009, 16'h0008, 1'b0, o, lat, bcnt);
        checks++;
        if ({o.r, o.co, o.ov, o.z} !== {16'h0001, 1'b1, 1'b1, 1'b0} || lat != 1 || bcnt != 1) begin
            errors++;
            $display("FAIL n1_9_plus_8 got r=%h co=%b ov=%b z=%b lat=%0d busy=%0d want r=1 co=1 ov=1 z=0 lat=1 busy=1",
                     o.r, o.co, o.ov, o.z, lat, bcnt);
        end
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(0, 15));
            b = 16'($urandom_range(0, 15));
            m = 1'($urandom);
            e = model(4, a, b, m);
            run_op(1'b1, a, b, m, o, lat, bcnt);
            checks++;
            if (o !== e || lat != 1) begin
                errors++;
                $display("FAIL n1_random_%0d a=%h b=%h m=%b got r=%h co=%b ov=%b z=%b lat=%0d want r=%h co=%b ov=%b z=%b lat=1",
                         i, a, b, m, o.r, o.co, o.ov, o.z, lat, e.r, e.co, e.ov, e.z);
            end
        end
    endtask

    task automatic test_random;
        res_t o;
        res_t e;
        int lat;
        int bcnt;
        logic [15:0] a;
        logic [15:0] b;
        logic m;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = (i % 8 == 0) ? a : 16'($urandom);
            m = 1'($urandom);
            e = model(16, a, b, m);
            run_op(1'b0, a, b, m, o, lat, bcnt);
            checks++;
            if (o !== e || lat != 4 || bcnt != 4) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h m=%b got r=%h co=%b ov=%b z=%b lat=%0d want r=%h co=%b ov=%b z=%b lat=4",
                         i, a, b, m, o.r, o.co, o.ov, o.z, lat, e.r, e.co, e.ov, e.z);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid_run();
        test_nibbles1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
